// File: rtl/bullet_ctrl.sv
// Player bullet generator: fire synchroniser, IDLE/LOAD/FLY flight FSM, pixel renderer, shot/hit counters.
// Optional inter-shot cooldown state enabled by defining BULLET_COOLDOWN_EN.
module bullet_ctrl #(
  parameter int          BULL_W      = 2,
  parameter int          BULL_H      = 6,
  parameter int          BULL_V      = 4,
  parameter int          X_OFF       = 7,
  parameter int          TOP_Y       = 0,
  parameter logic [2:0]  BULL_RGB    = 3'b110,
  parameter int          COOL_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        fire,
  input  logic [10:0] ship_x,
  input  logic [10:0] ship_y,
  input  logic        hit,
  output logic [10:0] bull_x,
  output logic [10:0] bull_y,
  output logic        bull_active,
  output logic        bull_on,
  output logic [2:0]  rgb,
  output logic [7:0]  shots,
  output logic [7:0]  hits
);

  localparam logic [10:0] LP_H         = 11'(BULL_H);
  localparam logic [10:0] LP_X_OFF     = 11'(X_OFF);
  localparam logic [10:0] LP_V         = 11'(BULL_V);
  localparam logic [10:0] LP_RETIRE_Y  = 11'(TOP_Y + BULL_V);

`ifdef BULLET_COOLDOWN_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLY, S_COOL} state_t;
  localparam state_t      LP_RETIRE_TO = S_COOL;
  localparam logic [7:0]  LP_COOL_LAST = 8'(COOL_FRAMES - 1);
  logic [7:0] r_cool_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLY} state_t;
  localparam state_t      LP_RETIRE_TO = S_IDLE;
`endif

  state_t      r_state, w_state_next;
  logic        r_s0, r_s1;
  logic [10:0] r_bull_x, r_bull_y;
  logic [7:0]  r_shots, r_hits;
  logic        w_fire_rise, w_frame_tick;
  logic        w_load, w_hit_retire, w_top_retire, w_step;
  logic [11:0] w_x_end, w_y_end;

  assign w_frame_tick = (pix_y == 11'd481) && (pix_x == 11'd0);
  assign w_fire_rise  = r_s0 & ~r_s1;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_hit_retire = 1'b0;
    w_top_retire = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: if (w_fire_rise && ship_y >= LP_H) w_state_next = S_LOAD;
      S_LOAD: begin
        w_load       = 1'b1;
        w_state_next = S_FLY;
      end
      S_FLY: begin
        if (hit)                                         w_hit_retire = 1'b1;
        else if (w_frame_tick && r_bull_y <= LP_RETIRE_Y) w_top_retire = 1'b1;
        else if (w_frame_tick)                           w_step       = 1'b1;
        if (w_hit_retire || w_top_retire) w_state_next = LP_RETIRE_TO;
      end
`ifdef BULLET_COOLDOWN_EN
      S_COOL: if (w_frame_tick && r_cool_cnt == LP_COOL_LAST) w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_bull_x <= '0;
      r_bull_y <= '0;
      r_shots  <= '0;
      r_hits   <= '0;
    end else begin
      r_state <= w_state_next;
      r_s0    <= fire;
      r_s1    <= r_s0;
      if (w_load) begin
        r_bull_x <= ship_x + LP_X_OFF;
        r_bull_y <= ship_y - LP_H;
        if (r_shots != 8'hFF) r_shots <= r_shots + 8'd1;
      end else if (w_hit_retire || w_top_retire) begin
        r_bull_x <= '0;
        r_bull_y <= '0;
      end else if (w_step) begin
        r_bull_y <= r_bull_y - LP_V;
      end
      if (w_hit_retire && r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
    end
  end

`ifdef BULLET_COOLDOWN_EN
  always_ff @(posedge clk) begin
    if (reset)                                  r_cool_cnt <= '0;
    else if (r_state != S_COOL)                 r_cool_cnt <= '0;
    else if (w_frame_tick)                      r_cool_cnt <= r_cool_cnt + 8'd1;
  end
`endif

  // Widened by one bit so a bullet at the right/bottom edge cannot wrap its extent.
  assign w_x_end = {1'b0, r_bull_x} + 12'(BULL_W - 1);
  assign w_y_end = {1'b0, r_bull_y} + 12'(BULL_H - 1);

  assign bull_active = (r_state == S_FLY);
  assign bull_on     = bull_active
                     && (pix_x >= r_bull_x) && ({1'b0, pix_x} <= w_x_end)
                     && (pix_y >= r_bull_y) && ({1'b0, pix_y} <= w_y_end);
  assign rgb         = (video_on && bull_on) ? BULL_RGB : 3'b000;
  assign bull_x      = r_bull_x;
  assign bull_y      = r_bull_y;
  assign shots       = r_shots;
  assign hits        = r_hits;

endmodule
